// File: rtl/acc_store_unit_if.sv
// acc_store_unit_if: memory write port of the ACC store path.
// master issues the write request, slave returns mem_ready.
interface acc_store_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] to_memory;
  logic              mem_ready;

  modport master (
    output mem_wr,
    output mem_addr,
    output to_memory,
    input  mem_ready
  );

  modport slave (
    input  mem_wr,
    input  mem_addr,
    input  to_memory,
    output mem_ready
  );
endinterface

// File: rtl/acc_store_unit.sv
// acc_store_unit: queues ACC/MAR stores and drains them to memory.
// Define STORE_FIFO_EN for a 2-entry queue; default is 1 entry.
module acc_store_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int STORE_BIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       control_signal,
  input  logic [DATA_W-1:0] from_ACC,
  input  logic [ADDR_W-1:0] from_MAR,
  acc_store_unit_if.master  mem,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

`ifdef STORE_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [1:0] CNT_FULL = 2'(DEPTH);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [1:0]       count;

  logic store_req;
  logic pop;
  logic push;
  logic drop;
  logic load;

  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic unused_ctrl;
  assign unused_ctrl =
    ^(control_signal & ~(32'd1 << STORE_BIT));

  assign store_req = control_signal[STORE_BIT];
  assign full      = (count == CNT_FULL);
  assign pop       = (state_q == WRITE) && mem.mem_ready;
  assign push      = store_req && (!full || pop);
  assign drop      = store_req && full && !pop;

  assign rd_ptr_nxt =
    (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
  assign wr_ptr_nxt =
    (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

  assign mem.mem_wr    = (state_q == WRITE);
  assign mem.mem_addr  = addr_q;
  assign mem.to_memory = data_q;
  assign busy = (count != 2'd0) || (state_q == WRITE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and head-load decision
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != 2'd0) begin
          state_d = WRITE;
          load    = 1'b1;
        end
      end
      WRITE: begin
        if (pop) begin
          if ((count > 2'd1) || push) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // head select; a lone entry pushed on the pop edge bypasses storage
  always_comb begin
    ld_addr = q_addr[rd_ptr];
    ld_data = q_data[rd_ptr];
    if (state_q == WRITE) begin
      if (count > 2'd1) begin
        ld_addr = q_addr[rd_ptr_nxt];
        ld_data = q_data[rd_ptr_nxt];
      end else begin
        ld_addr = from_MAR;
        ld_data = from_ACC;
      end
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // entry storage, no reset needed since count qualifies it
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_addr[wr_ptr] <= from_MAR;
      q_data[wr_ptr] <= from_ACC;
    end
  end

  // write address/data held until the next head load
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (load) begin
      addr_q <= ld_addr;
      data_q <= ld_data;
    end
  end

  // sticky dropped-store flag
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_store_unit.sv
// tb_acc_store_unit: directed checks of the ACC store path.
// Builds with or without STORE_FIFO_EN.
module tb_acc_store_unit;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl;
  logic [15:0] acc;
  logic [7:0]  mar;
  logic        busy;
  logic        full;
  logic        overflow;

  int vectors;
  int miscompares;

  logic [23:0] log_q [$];

  acc_store_unit_if #(.ADDR_W(8), .DATA_W(16)) mif ();

  acc_store_unit #(
    .DATA_W(16),
    .ADDR_W(8),
    .STORE_BIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .control_signal(ctrl),
    .from_ACC(acc),
    .from_MAR(mar),
    .mem(mif),
    .busy(busy),
    .full(full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every write that the next posedge completes
  always @(negedge clk) begin
    if (!rst && mif.mem_wr && mif.mem_ready)
      log_q.push_back({mif.mem_addr, mif.to_memory});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st,
                       input logic [7:0] a,
                       input logic [15:0] d);
    ctrl = st ? 32'h0000_0100 : 32'h0;
    mar  = a;
    acc  = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 8'h0, 16'h0);
    mif.mem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'hA5, 16'h5A5A);
    mif.mem_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (mif.mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mem_wr got %b exp 0", mif.mem_wr);
    end
    vectors++;
    if (mif.mem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_addr got %h exp 00", mif.mem_addr);
    end
    vectors++;
    if (mif.to_memory !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_data got %h exp 0000", mif.to_memory);
    end
    vectors++;
    if ({busy, full, overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flags got %b exp 000",
               {busy, full, overflow});
    end
    rst = 1'b0;
    drive(1'b0, 8'h0, 16'h0);
    tick();
    tick();
    vectors++;
    if ({busy, mif.mem_wr} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_nothing_queued got %b exp 00",
               {busy, mif.mem_wr});
    end
  endtask

  task automatic test_single();
    log_q.delete();
    mif.mem_ready = 1'b1;
    drive(1'b1, 8'h3C, 16'hBEEF);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    vectors++;
    if ({busy, mif.mem_wr} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_push got busy,wr=%b exp 10",
               {busy, mif.mem_wr});
    end
    tick();
    vectors++;
    if ({mif.mem_wr, mif.mem_addr, mif.to_memory}
        !== {1'b1, 8'h3C, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL single_write got %b/%h/%h exp 1/3c/beef",
               mif.mem_wr, mif.mem_addr, mif.to_memory);
    end
    tick();
    vectors++;
    if ({mif.mem_wr, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_done got wr,busy=%b exp 00",
               {mif.mem_wr, busy});
    end
    vectors++;
    if (mif.mem_addr !== 8'h3C) begin
      miscompares++;
      $display("FAIL single_hold_addr got %h exp 3c", mif.mem_addr);
    end
    tick();
    vectors++;
    if (log_q.size() != 1 || log_q[0] !== 24'h3CBEEF) begin
      miscompares++;
      $display("FAIL single_log got size %0d exp 1 entry 3cbeef",
               log_q.size());
    end
  endtask

  task automatic test_stall();
    log_q.delete();
    mif.mem_ready = 1'b0;
    drive(1'b1, 8'h10, 16'h1234);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({mif.mem_wr, mif.mem_addr, mif.to_memory}
          !== {1'b1, 8'h10, 16'h1234}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got %b/%h/%h exp 1/10/1234",
                 i, mif.mem_wr, mif.mem_addr, mif.to_memory);
      end
      tick();
    end
    mif.mem_ready = 1'b1;
    tick();
    vectors++;
    if ({mif.mem_wr, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_done got wr,busy=%b exp 00",
               {mif.mem_wr, busy});
    end
    tick();
    vectors++;
    if (log_q.size() != 1 || log_q[0] !== 24'h101234) begin
      miscompares++;
      $display("FAIL stall_log got size %0d exp 1 entry 101234",
               log_q.size());
    end
  endtask

  task automatic test_queue_order();
    log_q.delete();
    mif.mem_ready = 1'b0;
    drive(1'b1, 8'h01, 16'hAAAA);
    tick();
`ifdef STORE_FIFO_EN
    drive(1'b1, 8'h02, 16'h5555);
    tick();
    vectors++;
    if ({full, overflow} !== 2'b10) begin
      miscompares++;
      $display("FAIL order_full got full,ovf=%b exp 10",
               {full, overflow});
    end
    drive(1'b1, 8'h03, 16'h3333);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    vectors++;
    if ({full, overflow} !== 2'b11) begin
      miscompares++;
      $display("FAIL order_drop got full,ovf=%b exp 11",
               {full, overflow});
    end
    mif.mem_ready = 1'b1;
    tick();
    vectors++;
    if ({mif.mem_wr, mif.mem_addr, mif.to_memory}
        !== {1'b1, 8'h02, 16'h5555}) begin
      miscompares++;
      $display("FAIL order_second got %b/%h/%h exp 1/02/5555",
               mif.mem_wr, mif.mem_addr, mif.to_memory);
    end
    tick();
    vectors++;
    if ({mif.mem_wr, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL order_done got wr,busy=%b exp 00",
               {mif.mem_wr, busy});
    end
    tick();
    vectors++;
    if (log_q.size() != 2 || log_q[0] !== 24'h01AAAA ||
        log_q[1] !== 24'h025555) begin
      miscompares++;
      $display("FAIL order_log got size %0d exp 01aaaa,025555",
               log_q.size());
    end
`else
    vectors++;
    if ({full, overflow} !== 2'b10) begin
      miscompares++;
      $display("FAIL order_full got full,ovf=%b exp 10",
               {full, overflow});
    end
    drive(1'b1, 8'h02, 16'h5555);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    vectors++;
    if ({full, overflow} !== 2'b11) begin
      miscompares++;
      $display("FAIL order_drop got full,ovf=%b exp 11",
               {full, overflow});
    end
    mif.mem_ready = 1'b1;
    tick();
    vectors++;
    if ({mif.mem_wr, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL order_done got wr,busy=%b exp 00",
               {mif.mem_wr, busy});
    end
    tick();
    vectors++;
    if (log_q.size() != 1 || log_q[0] !== 24'h01AAAA) begin
      miscompares++;
      $display("FAIL order_log got size %0d exp 01aaaa only",
               log_q.size());
    end
`endif
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL order_sticky got %b exp 1", overflow);
    end
    apply_reset();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL order_ovf_clear got %b exp 0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    log_q.delete();
    mif.mem_ready = 1'b0;
    drive(1'b1, 8'h20, 16'h1111);
    tick();
`ifdef STORE_FIFO_EN
    drive(1'b1, 8'h21, 16'h2222);
    tick();
    mif.mem_ready = 1'b1;
    drive(1'b1, 8'h22, 16'h3333);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    vectors++;
    if ({full, overflow, mif.mem_wr, mif.mem_addr}
        !== {3'b101, 8'h21}) begin
      miscompares++;
      $display("FAIL pp_accept got full,ovf,wr=%b addr %h exp 101/21",
               {full, overflow, mif.mem_wr}, mif.mem_addr);
    end
    tick();
    vectors++;
    if ({mif.mem_wr, mif.mem_addr, mif.to_memory}
        !== {1'b1, 8'h22, 16'h3333}) begin
      miscompares++;
      $display("FAIL pp_last got %b/%h/%h exp 1/22/3333",
               mif.mem_wr, mif.mem_addr, mif.to_memory);
    end
    tick();
    tick();
    vectors++;
    if (log_q.size() != 3 || log_q[0] !== 24'h201111 ||
        log_q[1] !== 24'h212222 || log_q[2] !== 24'h223333) begin
      miscompares++;
      $display("FAIL pp_log got size %0d exp 20,21,22",
               log_q.size());
    end
`else
    drive(1'b0, 8'h0, 16'h0);
    tick();
    mif.mem_ready = 1'b1;
    drive(1'b1, 8'h21, 16'h2222);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    vectors++;
    if ({full, overflow, mif.mem_wr, mif.mem_addr, mif.to_memory}
        !== {3'b101, 8'h21, 16'h2222}) begin
      miscompares++;
      $display("FAIL pp_accept got full,ovf,wr=%b %h/%h exp 101/21/2222",
               {full, overflow, mif.mem_wr},
               mif.mem_addr, mif.to_memory);
    end
    tick();
    tick();
    vectors++;
    if (log_q.size() != 2 || log_q[0] !== 24'h201111 ||
        log_q[1] !== 24'h212222) begin
      miscompares++;
      $display("FAIL pp_log got size %0d exp 20,21", log_q.size());
    end
`endif
    vectors++;
    if ({mif.mem_wr, busy, full, overflow} !== 4'b0000) begin
      miscompares++;
      $display("FAIL pp_idle got %b exp 0000",
               {mif.mem_wr, busy, full, overflow});
    end
  endtask

  task automatic test_back_to_back();
    log_q.delete();
    mif.mem_ready = 1'b1;
    drive(1'b1, 8'h40, 16'hC000);
    tick();
    drive(1'b0, 8'h0, 16'h0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 8'(8'h40 + i), 16'(16'hC000 + i));
      tick();
      vectors++;
      if ({mif.mem_wr, mif.mem_addr} !== {1'b1, 8'(8'h40 + i)}) begin
        miscompares++;
        $display("FAIL b2b[%0d] got wr %b addr %h exp 1/%h",
                 i, mif.mem_wr, mif.mem_addr, 8'(8'h40 + i));
      end
    end
    drive(1'b0, 8'h0, 16'h0);
    tick();
    vectors++;
    if ({mif.mem_wr, busy, overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_done got wr,busy,ovf=%b exp 000",
               {mif.mem_wr, busy, overflow});
    end
    tick();
    vectors++;
    if (log_q.size() != 4 || log_q[0] !== 24'h40C000 ||
        log_q[3] !== 24'h43C003) begin
      miscompares++;
      $display("FAIL b2b_log got size %0d exp 4 (40..43)",
               log_q.size());
    end
  endtask

  task automatic test_rst_mid();
    log_q.delete();
    mif.mem_ready = 1'b0;
    drive(1'b1, 8'h50, 16'hDEAD);
    tick();
    drive(1'b1, 8'h51, 16'hF00D);
    tick();
    vectors++;
    if (mif.mem_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_pre got wr %b exp 1", mif.mem_wr);
    end
    rst = 1'b1;
    drive(1'b1, 8'h52, 16'h7777);
    tick();
    vectors++;
    if ({mif.mem_wr, busy, full, overflow} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rmid_flush got %b exp 0000",
               {mif.mem_wr, busy, full, overflow});
    end
    rst = 1'b0;
    drive(1'b0, 8'h0, 16'h0);
    mif.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if ({mif.mem_wr, busy} !== 2'b00 || log_q.size() != 0) begin
      miscompares++;
      $display("FAIL rmid_after got wr,busy=%b writes %0d exp 00/0",
               {mif.mem_wr, busy}, log_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    ctrl = 32'h0;
    acc  = 16'h0;
    mar  = 8'h0;
    mif.mem_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_queue_order();
    test_push_pop_full();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
